// File: rtl/gpio_irq_port_pkg.sv
// Register map shared by the GPIO port, its address decode and its bench.
package gpio_irq_port_pkg;

  typedef enum logic [2:0] {
    GPIO_DATA = 3'd0,
    GPIO_DIR  = 3'd1,
    GPIO_RISE = 3'd2,
    GPIO_IE   = 3'd3,
    GPIO_PEND = 3'd4
  } gpio_reg_e;

  localparam int GPIO_BUS_W = 32;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pin synchroniser plus edge detector; ev is valid SYNC cycles after a pin change.
// Events are held off for SYNC+1 cycles after reset so pre-reset pin state never pends.
module gpio_sync_edge #(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] pin_in,
  input  logic [W-1:0] rise_sel,
  output logic [W-1:0] synced,
  output logic [W-1:0] ev
);

  logic [W-1:0] sync_q [SYNC];
  logic [W-1:0] prev;
  logic [2:0]   arm;

  // The chain keeps sampling through reset so it is settled by release.
  always_ff @(posedge clk) begin
    sync_q[0] <= pin_in;
    for (int k = 1; k < SYNC; k++) begin
      sync_q[k] <= sync_q[k-1];
    end
    prev <= sync_q[SYNC-1];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      arm <= 3'(SYNC + 1);
    end else if (arm != 3'd0) begin
      arm <= arm - 3'd1;
    end
  end

  assign synced = sync_q[SYNC-1];
  assign ev     = (arm == 3'd0) ?
                  ((rise_sel & synced & ~prev) | (~rise_sel & ~synced & prev)) : '0;

endmodule

// File: rtl/gpio_irq_port.sv
// W-pin GPIO port: output/direction regs, synced readback, per-pin edge interrupt with W1C pending.
// Pin edges reach PEND/irq SYNC+1 edges after the change; register writes take effect at the next edge.
module gpio_irq_port
  import gpio_irq_port_pkg::*;
#(
  parameter int W    = 8,
  parameter int SYNC = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         sel,
  input  logic         wr,
  input  logic [2:0]   regadr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  output logic         irq,
  input  logic [W-1:0] pin_in,
  output logic [W-1:0] pin_out,
  output logic [W-1:0] pin_oe
);

  logic [W-1:0] data_q;
  logic [W-1:0] dir_q;
  logic [W-1:0] rise_q;
  logic [W-1:0] ie_q;
  logic [W-1:0] pend_q;
  logic [W-1:0] synced;
  logic [W-1:0] ev;
  logic [W-1:0] clr;
  logic         we;
  logic         unused_wdata;

  gpio_sync_edge #(.W(W), .SYNC(SYNC)) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .pin_in   (pin_in),
    .rise_sel (rise_q),
    .synced   (synced),
    .ev       (ev)
  );

  assign we           = sel & wr;
  assign unused_wdata = ^wdata;

  always_comb begin
    clr = '0;
    if (we && regadr == GPIO_PEND) begin
      clr = wdata[W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      dir_q  <= '0;
      rise_q <= '0;
      ie_q   <= '0;
      pend_q <= '0;
    end else begin
      // A new edge in the same cycle as a clear keeps the bit set.
      pend_q <= ev | (pend_q & ~clr);
      if (we) begin
        case (regadr)
          GPIO_DATA: data_q <= wdata[W-1:0];
          GPIO_DIR:  dir_q  <= wdata[W-1:0];
          GPIO_RISE: rise_q <= wdata[W-1:0];
          GPIO_IE:   ie_q   <= wdata[W-1:0];
          default:   ;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (regadr)
      GPIO_DATA: rdata = GPIO_BUS_W'(synced);
      GPIO_DIR:  rdata = GPIO_BUS_W'(dir_q);
      GPIO_RISE: rdata = GPIO_BUS_W'(rise_q);
      GPIO_IE:   rdata = GPIO_BUS_W'(ie_q);
      GPIO_PEND: rdata = GPIO_BUS_W'(pend_q);
      default:   rdata = '0;
    endcase
  end

  assign pin_out = data_q;
  assign pin_oe  = dir_q;
  assign irq     = |(pend_q & ie_q);

endmodule

// File: tb/tb_gpio_irq_port.sv
// Directed and random stimulus for gpio_irq_port against a cycle-level register model.
module tb_gpio_irq_port;
  import gpio_irq_port_pkg::*;

  localparam int SYNC = 2;

  logic        clk;
  logic        rst;
  logic        sel;
  logic        wr;
  logic [2:0]  regadr;
  logic [31:0] wdata;
  logic [31:0] rdata, rdata32, rdata4;
  logic        irq, irq32, irq4;
  logic [7:0]  pin_in, pin_out, pin_oe;
  logic [31:0] pin_in32, pin_out32, pin_oe32;
  logic [3:0]  pin_in4, pin_out4, pin_oe4;

  int vectors;
  int miscompares;

  gpio_irq_port #(.W(8), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .regadr(regadr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe)
  );

  gpio_irq_port #(.W(32), .SYNC(SYNC)) dut32 (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .regadr(regadr), .wdata(wdata),
    .rdata(rdata32), .irq(irq32), .pin_in(pin_in32), .pin_out(pin_out32), .pin_oe(pin_oe32)
  );

  gpio_irq_port #(.W(4), .SYNC(3)) dut4 (
    .clk(clk), .rst(rst), .sel(sel), .wr(wr), .regadr(regadr), .wdata(wdata),
    .rdata(rdata4), .irq(irq4), .pin_in(pin_in4), .pin_out(pin_out4), .pin_oe(pin_oe4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model of the 8-bit port: register values plus the history of sampled pins.
  logic [7:0] m_out, m_dir, m_rise, m_ie, m_pend;
  logic [7:0] hist[$];
  int         since_rel;

  always @(posedge clk) begin : model
    logic [7:0] cur, prv, ev, clr;
    cur = (hist.size() > SYNC - 1) ? hist[SYNC-1] : 8'h00;
    prv = (hist.size() > SYNC)     ? hist[SYNC]   : 8'h00;
    ev  = 8'h00;
    if (rst && since_rel >= SYNC + 1)
      ev = (m_rise & cur & ~prv) | (~m_rise & ~cur & prv);
    if (!rst) begin
      m_out = 8'h00; m_dir = 8'h00; m_rise = 8'h00; m_ie = 8'h00; m_pend = 8'h00;
      since_rel = 0;
    end else begin
      since_rel++;
      clr    = (sel && wr && regadr == GPIO_PEND) ? wdata[7:0] : 8'h00;
      m_pend = ev | (m_pend & ~clr);
      if (sel && wr) begin
        if (regadr == GPIO_DATA) m_out  = wdata[7:0];
        if (regadr == GPIO_DIR)  m_dir  = wdata[7:0];
        if (regadr == GPIO_RISE) m_rise = wdata[7:0];
        if (regadr == GPIO_IE)   m_ie   = wdata[7:0];
      end
    end
    hist.push_front(pin_in);
    if (hist.size() > 8) void'(hist.pop_back());
  end

  function automatic logic [31:0] m_rdata(input logic [2:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == GPIO_DATA && hist.size() >= SYNC) v = hist[SYNC-1];
    if (a == GPIO_DIR)  v = m_dir;
    if (a == GPIO_RISE) v = m_rise;
    if (a == GPIO_IE)   v = m_ie;
    if (a == GPIO_PEND) v = m_pend;
    return {24'h0, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    chk("pin_out", {24'h0, pin_out}, {24'h0, m_out});
    chk("pin_oe",  {24'h0, pin_oe},  {24'h0, m_dir});
    chk("irq",     {31'h0, irq},     {31'h0, |(m_pend & m_ie)});
    chk("rdata",   rdata,            m_rdata(regadr));
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
    chk_model();
  endtask

  task automatic wr_reg(input logic [2:0] adr, input logic [31:0] val);
    sel = 1'b1; wr = 1'b1; regadr = adr; wdata = val;
    cycle();
    sel = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] adr, input logic [31:0] exp);
    regadr = adr;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    vectors = 0; miscompares = 0; since_rel = 0;
    rst = 1'b0; sel = 1'b0; wr = 1'b0; regadr = GPIO_DIR; wdata = 32'h0;
    pin_in = 8'hFF; pin_in32 = 32'h0; pin_in4 = 4'hF;

    // Reset with all pins high, then no spurious pend after release.
    repeat (3) cycle();
    chk("rst_pin_out", {24'h0, pin_out}, 32'h0);
    chk("rst_pin_oe",  {24'h0, pin_oe},  32'h0);
    chk("rst_irq",     {31'h0, irq},     32'h0);
    rd_chk("rst_dir",  GPIO_DIR,  32'h0);
    rd_chk("rst_rise", GPIO_RISE, 32'h0);
    rd_chk("rst_ie",   GPIO_IE,   32'h0);
    rd_chk("rst_pend", GPIO_PEND, 32'h0);
    rst = 1'b1;
    repeat (10) cycle();
    rd_chk("post_rst_pend", GPIO_PEND, 32'h0);

    // Outputs and synced readback.
    wr_reg(GPIO_DIR, 32'h0F);
    chk("dir_pin_oe", {24'h0, pin_oe}, 32'h0F);
    wr_reg(GPIO_DATA, 32'hA5);
    chk("data_pin_out", {24'h0, pin_out}, 32'hA5);
    pin_in = 8'h3C;
    regadr = GPIO_DIR;
    repeat (SYNC) cycle();
    rd_chk("data_readback", GPIO_DATA, 32'h3C);
    cycle();
    rd_chk("fall_default_pend", GPIO_PEND, 32'hC3);
    wr_reg(GPIO_PEND, 32'hFF);
    rd_chk("pend_cleared", GPIO_PEND, 32'h0);

    // Rising-edge interrupt latency on bit 0.
    wr_reg(GPIO_RISE, 32'h01);
    wr_reg(GPIO_IE, 32'h01);
    pin_in = 8'h3D;
    for (int i = 1; i <= SYNC + 1; i++) begin
      cycle();
      chk("irq_latency", {31'h0, irq}, (i == SYNC + 1) ? 32'h1 : 32'h0);
    end
    rd_chk("rise_pend", GPIO_PEND, 32'h01);
    wr_reg(GPIO_PEND, 32'h01);
    pin_in = 8'h3C;
    repeat (4) cycle();
    rd_chk("fall_no_pend", GPIO_PEND, 32'h0);

    // Clear racing a new edge: set wins, then a plain clear drops irq.
    pin_in = 8'h3D;
    repeat (SYNC + 1) cycle();
    rd_chk("race_pre", GPIO_PEND, 32'h01);
    pin_in = 8'h3C;
    repeat (SYNC + 1) cycle();
    pin_in = 8'h3D;
    repeat (SYNC) cycle();
    wr_reg(GPIO_PEND, 32'h01);
    rd_chk("race_set_wins", GPIO_PEND, 32'h01);
    chk("race_irq", {31'h0, irq}, 32'h1);
    wr_reg(GPIO_PEND, 32'h01);
    rd_chk("w1c_clear", GPIO_PEND, 32'h0);
    chk("w1c_irq", {31'h0, irq}, 32'h0);

    // IE masks irq only; enabling it later raises irq.
    wr_reg(GPIO_IE, 32'h00);
    wr_reg(GPIO_RISE, 32'h00);
    pin_in = 8'h35;
    repeat (SYNC + 1) cycle();
    rd_chk("mask_pend", GPIO_PEND, 32'h08);
    chk("mask_irq", {31'h0, irq}, 32'h0);
    wr_reg(GPIO_IE, 32'h08);
    chk("ie_irq", {31'h0, irq}, 32'h1);
    wr_reg(GPIO_PEND, 32'hFF);
    chk("ie_irq_clr", {31'h0, irq}, 32'h0);

    // Width handling on the 32- and 4-pin instances.
    wr_reg(GPIO_DATA, 32'hFFFF_FFFF);
    chk("w32_pin_out", pin_out32, 32'hFFFF_FFFF);
    chk("w4_pin_out", {28'h0, pin_out4}, 32'hF);
    regadr = 3'd6;
    #1;
    chk("w32_unmapped", rdata32, 32'h0);
    chk("w8_unmapped", rdata, 32'h0);
    regadr = GPIO_DATA;
    #1;
    chk("w4_data_read", rdata4, 32'h0000_000F);
    wr_reg(GPIO_DIR, 32'hFFFF_FFFF);
    chk("w4_dir_read", rdata4, 32'h0000_000F);
    chk("w32_dir_read", rdata32, 32'hFFFF_FFFF);
    wr_reg(GPIO_PEND, 32'hFF);
    wr_reg(3'd7, 32'hFFFF_FFFF);
    rd_chk("reg7_read", 3'd7, 32'h0);

    // Random bus traffic, pin activity and occasional resets.
    for (int n = 0; n < 400; n++) begin
      rst    = ($urandom_range(0, 63) != 0);
      sel    = $urandom_range(0, 1) == 1;
      wr     = $urandom_range(0, 1) == 1;
      regadr = 3'($urandom_range(0, 7));
      wdata  = $urandom;
      if ($urandom_range(0, 3) == 0) pin_in = 8'($urandom);
      cycle();
    end
    rst = 1'b1; sel = 1'b0; wr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
